fifo_flush_unpacker: RTL and testbench



---
 rtl/fifo_flush_pkg.sv | 32 +++
 rtl/fifo_flush_unpacker_nib_shift_out.sv | 47 ++++
 rtl/fifo_flush_unpacker.sv | 101 ++++++++++
 tb/tb_fifo_flush_unpacker.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_flush_pkg.sv
// Shared types and constants for the fifo_flush consumer side.
package fifo_flush_pkg;

  localparam int unsigned NIBBLES = 8;
  localparam int unsigned NIB_W   = 4;
  localparam int unsigned WORD_W  = NIB_W * NIBBLES;
  localparam int unsigned CNT_W   = $clog2(NIBBLES + 1);
  localparam logic [NIB_W-1:0] PAD_NIBBLE = 4'hC;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    EMIT = 2'd2
  } state_t;

  // Nibbles left after stripping the run of pad nibbles that starts at the MSB end.
  function automatic logic [CNT_W-1:0] valid_nibbles(input logic [WORD_W-1:0] word);
    logic             in_pad;
    logic [CNT_W-1:0] n;
    in_pad = 1'b1;
    n      = CNT_W'(NIBBLES);
    for (int i = NIBBLES - 1; i >= 0; i--) begin
      if (in_pad && (word[i*NIB_W +: NIB_W] == PAD_NIBBLE)) begin
        n = n - CNT_W'(1);
      end else begin
        in_pad = 1'b0;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/fifo_flush_unpacker_nib_shift_out.sv
// Loadable nibble shift register that streams its valid nibbles over a valid/ready port.
module nib_shift_out
  import fifo_flush_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [WORD_W-1:0] load_word,
  input  logic [CNT_W-1:0]  load_count,
  input  logic              ready,
  output logic              valid,
  output logic [NIB_W-1:0]  data,
  output logic              last
);

  logic [WORD_W-1:0] word;
  logic [CNT_W-1:0]  remaining;

  // Present nibble stays on data until accepted; next nibble appears on the accept edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      word      <= '0;
      remaining <= '0;
      valid     <= 1'b0;
      data      <= '0;
      last      <= 1'b0;
    end else if (load) begin
      word      <= load_word;
      remaining <= load_count;
      valid     <= (load_count != '0);
      data      <= load_word[NIB_W-1:0];
      last      <= (load_count == CNT_W'(1));
    end else if (valid && ready) begin
      if (last) begin
        valid     <= 1'b0;
        last      <= 1'b0;
        remaining <= '0;
      end else begin
        word      <= word >> NIB_W;
        remaining <= remaining - CNT_W'(1);
        data      <= word[2*NIB_W-1:NIB_W];
        last      <= (remaining == CNT_W'(2));
      end
    end
  end

endmodule

// File: rtl/fifo_flush_unpacker.sv
// Requests flush words from fifo_flush, strips trailing pad and streams nibbles oldest first.
module fifo_flush_unpacker
  import fifo_flush_pkg::*;
#(
  parameter int unsigned CAPTURE_LAT = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable_i,
  input  logic              fifo_empty_i,
  output logic              fifo_flush_o,
  input  logic [WORD_W-1:0] fifo_rd_data_i,
  output logic              nib_valid_o,
  output logic [NIB_W-1:0]  nib_data_o,
  output logic              nib_last_o,
  input  logic              nib_ready_i,
  output logic              busy_o,
  output logic [15:0]       word_cnt_o
);

  localparam int unsigned LAT_W = $clog2(CAPTURE_LAT + 1);

  state_t             state, state_next;
  logic [LAT_W-1:0]   lat_cnt, lat_next;
  logic               flush_next;
  logic [15:0]        word_cnt_next;
  logic               load;
  logic [CNT_W-1:0]   n_valid;

  assign n_valid = valid_nibbles(fifo_rd_data_i);

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      lat_cnt      <= '0;
      fifo_flush_o <= 1'b0;
      busy_o       <= 1'b0;
      word_cnt_o   <= '0;
    end else begin
      state        <= state_next;
      lat_cnt      <= lat_next;
      fifo_flush_o <= flush_next;
      busy_o       <= (state_next != IDLE);
      word_cnt_o   <= word_cnt_next;
    end
  end

  // lat_cnt counts edges since flush rose; the word is sampled on edge CAPTURE_LAT.
  always_comb begin
    state_next    = state;
    lat_next      = lat_cnt;
    flush_next    = fifo_flush_o;
    word_cnt_next = word_cnt_o;
    load          = 1'b0;
    unique case (state)
      IDLE: begin
        if (enable_i && !fifo_empty_i) begin
          flush_next = 1'b1;
          lat_next   = '0;
          state_next = REQ;
        end
      end
      REQ: begin
        if (lat_cnt == LAT_W'(CAPTURE_LAT - 1)) begin
          flush_next = 1'b0;
          if (n_valid == '0) begin
            state_next = IDLE;
          end else begin
            load          = 1'b1;
            word_cnt_next = word_cnt_o + 16'd1;
            state_next    = EMIT;
          end
        end else begin
          lat_next = lat_cnt + LAT_W'(1);
        end
      end
      EMIT: begin
        if (nib_valid_o && nib_ready_i && nib_last_o) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        flush_next = 1'b0;
      end
    endcase
  end

  nib_shift_out u_shift (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_word  (fifo_rd_data_i),
    .load_count (n_valid),
    .ready      (nib_ready_i),
    .valid      (nib_valid_o),
    .data       (nib_data_o),
    .last       (nib_last_o)
  );

endmodule

// File: tb/tb_fifo_flush_unpacker.sv
// Directed self-checking bench for fifo_flush_unpacker.
module tb_fifo_flush_unpacker;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable_i;
  logic        fifo_empty_i;
  logic        fifo_flush_o;
  logic [31:0] fifo_rd_data_i;
  logic        nib_valid_o;
  logic [3:0]  nib_data_o;
  logic        nib_last_o;
  logic        nib_ready_i;
  logic        busy_o;
  logic [15:0] word_cnt_o;

  int checks   = 0;
  int failures = 0;

  fifo_flush_unpacker dut (
    .clk            (clk),
    .reset          (reset),
    .enable_i       (enable_i),
    .fifo_empty_i   (fifo_empty_i),
    .fifo_flush_o   (fifo_flush_o),
    .fifo_rd_data_i (fifo_rd_data_i),
    .nib_valid_o    (nib_valid_o),
    .nib_data_o     (nib_data_o),
    .nib_last_o     (nib_last_o),
    .nib_ready_i    (nib_ready_i),
    .busy_o         (busy_o),
    .word_cnt_o     (word_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present a word with the FIFO non-empty until flush rises, then report the FIFO empty.
  task automatic request(input logic [31:0] w, output bit ok);
    fifo_rd_data_i = w;
    fifo_empty_i   = 1'b0;
    enable_i       = 1'b1;
    ok             = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      tick();
      if (fifo_flush_o) ok = 1'b1;
    end
    fifo_empty_i = 1'b1;
  endtask

  task automatic wait_valid(output bit ok);
    ok = nib_valid_o;
    for (int i = 0; i < 10 && !ok; i++) begin
      tick();
      if (nib_valid_o) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable_i = 1'b0; fifo_empty_i = 1'b1;
    fifo_rd_data_i = '0; nib_ready_i = 1'b0;
    tick(); tick();
    checks++;
    if ({fifo_flush_o, nib_valid_o, nib_data_o, nib_last_o, busy_o, word_cnt_o} !== 25'd0) begin
      failures++;
      $display("FAIL reset_outputs got flush=%b valid=%b data=%h last=%b busy=%b cnt=%0d want all 0",
               fifo_flush_o, nib_valid_o, nib_data_o, nib_last_o, busy_o, word_cnt_o);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_idle();
    enable_i = 1'b1; fifo_empty_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (fifo_flush_o !== 1'b0 || busy_o !== 1'b0) begin
        failures++;
        $display("FAIL idle_cycle%0d got flush=%b busy=%b want 0 0", i, fifo_flush_o, busy_o);
      end
    end
  endtask

  task automatic test_partial();
    bit ok;
    logic [3:0] exp_nib [3];
    exp_nib = '{4'h1, 4'h2, 4'h3};
    nib_ready_i = 1'b1;
    request(32'hCCCCC321, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL partial_flush_rise got none want flush within 10 cycles"); end
    checks++;
    if (busy_o !== 1'b1) begin failures++; $display("FAIL partial_busy got %b want 1", busy_o); end
    // Flush held through the capture latency, no output yet.
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (fifo_flush_o !== 1'b1 || nib_valid_o !== 1'b0) begin
        failures++;
        $display("FAIL partial_req%0d got flush=%b valid=%b want 1 0", i, fifo_flush_o, nib_valid_o);
      end
    end
    tick();
    checks++;
    if (fifo_flush_o !== 1'b0 || word_cnt_o !== 16'd1) begin
      failures++;
      $display("FAIL partial_capture got flush=%b cnt=%0d want 0 1", fifo_flush_o, word_cnt_o);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (nib_valid_o !== 1'b1 || nib_data_o !== exp_nib[i] || nib_last_o !== (i == 2)) begin
        failures++;
        $display("FAIL partial_nib%0d got v=%b d=%h l=%b want 1 %h %b",
                 i, nib_valid_o, nib_data_o, nib_last_o, exp_nib[i], (i == 2));
      end
      tick();
    end
    checks++;
    if (nib_valid_o !== 1'b0 || busy_o !== 1'b0 || word_cnt_o !== 16'd1) begin
      failures++;
      $display("FAIL partial_done got v=%b busy=%b cnt=%0d want 0 0 1", nib_valid_o, busy_o, word_cnt_o);
    end
  endtask

  task automatic test_full();
    bit ok;
    logic [3:0] exp_nib [8];
    exp_nib = '{4'h1, 4'hC, 4'h3, 4'h4, 4'h5, 4'h6, 4'hC, 4'h7};
    nib_ready_i = 1'b1;
    request(32'h7C6543C1, ok);
    wait_valid(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL full_valid got none want valid within bound"); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (nib_valid_o !== 1'b1 || nib_data_o !== exp_nib[i] || nib_last_o !== (i == 7)) begin
        failures++;
        $display("FAIL full_nib%0d got v=%b d=%h l=%b want 1 %h %b",
                 i, nib_valid_o, nib_data_o, nib_last_o, exp_nib[i], (i == 7));
      end
      tick();
    end
    checks++;
    if (nib_valid_o !== 1'b0 || word_cnt_o !== 16'd2) begin
      failures++;
      $display("FAIL full_done got v=%b cnt=%0d want 0 2", nib_valid_o, word_cnt_o);
    end
  endtask

  task automatic test_back_pressure();
    bit ok;
    nib_ready_i = 1'b0;
    request(32'hCCCCCCBA, ok);
    wait_valid(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL bp_valid got none want valid within bound"); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (nib_valid_o !== 1'b1 || nib_data_o !== 4'hA || nib_last_o !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold%0d got v=%b d=%h l=%b want 1 a 0", i, nib_valid_o, nib_data_o, nib_last_o);
      end
      tick();
    end
    nib_ready_i = 1'b1;
    checks++;
    if (nib_valid_o !== 1'b1 || nib_data_o !== 4'hA) begin
      failures++;
      $display("FAIL bp_first got v=%b d=%h want 1 a", nib_valid_o, nib_data_o);
    end
    tick();
    checks++;
    if (nib_valid_o !== 1'b1 || nib_data_o !== 4'hB || nib_last_o !== 1'b1) begin
      failures++;
      $display("FAIL bp_second got v=%b d=%h l=%b want 1 b 1", nib_valid_o, nib_data_o, nib_last_o);
    end
    tick();
    checks++;
    if (nib_valid_o !== 1'b0 || word_cnt_o !== 16'd3) begin
      failures++;
      $display("FAIL bp_done got v=%b cnt=%0d want 0 3", nib_valid_o, word_cnt_o);
    end
  endtask

  task automatic test_all_pad();
    bit ok;
    nib_ready_i = 1'b1;
    request(32'hCCCCCCCC, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL pad_flush_rise got none want flush within 10 cycles"); end
    tick(); tick(); tick();
    checks++;
    if (fifo_flush_o !== 1'b0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL pad_to_idle got flush=%b busy=%b want 0 0", fifo_flush_o, busy_o);
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (nib_valid_o !== 1'b0) begin
        failures++;
        $display("FAIL pad_no_valid%0d got %b want 0", i, nib_valid_o);
      end
      tick();
    end
    checks++;
    if (word_cnt_o !== 16'd3) begin
      failures++;
      $display("FAIL pad_cnt got %0d want 3", word_cnt_o);
    end
  endtask

  task automatic test_reset_in_emit();
    bit ok;
    nib_ready_i = 1'b1;
    request(32'hCCC54321, ok);
    wait_valid(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL rst_emit_valid got none want valid within bound"); end
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (nib_data_o !== 4'(i + 1)) begin
        failures++;
        $display("FAIL rst_emit_nib%0d got %h want %h", i, nib_data_o, 4'(i + 1));
      end
      tick();
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({fifo_flush_o, nib_valid_o, nib_data_o, nib_last_o, busy_o, word_cnt_o} !== 25'd0) begin
      failures++;
      $display("FAIL rst_emit_outputs got flush=%b valid=%b data=%h last=%b busy=%b cnt=%0d want all 0",
               fifo_flush_o, nib_valid_o, nib_data_o, nib_last_o, busy_o, word_cnt_o);
    end
    reset = 1'b0;
    request(32'hCCCCCC98, ok);
    wait_valid(ok);
    checks++;
    if (nib_valid_o !== 1'b1 || nib_data_o !== 4'h8 || nib_last_o !== 1'b0 || word_cnt_o !== 16'd1) begin
      failures++;
      $display("FAIL rst_new_nib0 got v=%b d=%h l=%b cnt=%0d want 1 8 0 1",
               nib_valid_o, nib_data_o, nib_last_o, word_cnt_o);
    end
    tick();
    checks++;
    if (nib_valid_o !== 1'b1 || nib_data_o !== 4'h9 || nib_last_o !== 1'b1) begin
      failures++;
      $display("FAIL rst_new_nib1 got v=%b d=%h l=%b want 1 9 1", nib_valid_o, nib_data_o, nib_last_o);
    end
    tick();
    checks++;
    if (nib_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL rst_new_done got v=%b busy=%b want 0 0", nib_valid_o, busy_o);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_partial();
    test_full();
    test_back_pressure();
    test_all_pad();
    test_reset_in_emit();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
